// File: rtl/encoder_8to3_12.sv
// encoder_8to3_12: registered 8-to-3 priority encoder with enable.
// One pipeline stage. Din/En are sampled on the rising clk edge, and the
// result appears on E0/V after that edge.
// MSB_PRIORITY = 1 selects the highest set bit; 0 selects the lowest set bit.
// Optional macro ENC_MULTIHOT_ERR_EN adds a registered Err output.
// Err flags an enabled request vector that has more than one bit set.
module encoder_8to3_12 #(
    parameter bit MSB_PRIORITY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic [7:0] Din,
    output logic [2:0] E0,
    output logic       V
`ifdef ENC_MULTIHOT_ERR_EN
    ,
    output logic       Err
`endif
);

    logic [2:0] win_idx;
    logic       any_set;

    // Combinational priority pick. The last hit in the scan order wins.
    always_comb begin
        // NOTE: assign a default to every output before the loop.
        // Otherwise a path that writes nothing infers a latch.
        win_idx = 3'b000;
        any_set = |Din;
        for (int i = 0; i < 8; i++) begin
            if (MSB_PRIORITY) begin
                // Ascending scan: the highest set index is written last.
                if (Din[i]) win_idx = i[2:0];
            end else begin
                // Descending scan: the lowest set index is written last.
                if (Din[7 - i]) win_idx = 3'(7 - i);
            end
        end
    end

    // Output register. En=0 clears the outputs instead of holding them,
    // which also keeps X/Z on Din away from the outputs.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: use non-blocking assignments for registered state.
        // All flops then update together from pre-edge values.
        if (rst) begin
            E0 <= 3'b000;
            V  <= 1'b0;
        end else if (En) begin
            E0 <= win_idx;
            V  <= any_set;
        end else begin
            E0 <= 3'b000;
            V  <= 1'b0;
        end
    end

`ifdef ENC_MULTIHOT_ERR_EN
    logic multi_hot;

    // Clearing the lowest set bit leaves a nonzero value
    // exactly when two or more bits are set.
    always_comb begin
        multi_hot = (Din & (Din - 8'd1)) != 8'd0;
    end

    // Error flag register. It uses the same gating as E0/V.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Err <= 1'b0;
        end else begin
            Err <= En & multi_hot;
        end
    end
`endif

endmodule

// File: tb/tb_encoder_8to3_12.sv
// tb_encoder_8to3_12: self-checking bench for encoder_8to3_12.
// It drives two instances from the same inputs: MSB-priority and LSB-priority.
// It compares both against an arithmetic reference model.
// Define ENC_MULTIHOT_ERR_EN to also exercise the Err output.
module tb_encoder_8to3_12;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] e0_m, e0_l;
    logic       v_m, v_l;
`ifdef ENC_MULTIHOT_ERR_EN
    logic       err_m, err_l;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encoder_8to3_12 #(.MSB_PRIORITY(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .En(en), .Din(din), .E0(e0_m), .V(v_m)
`ifdef ENC_MULTIHOT_ERR_EN
        , .Err(err_m)
`endif
    );

    encoder_8to3_12 #(.MSB_PRIORITY(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .En(en), .Din(din), .E0(e0_l), .V(v_l)
`ifdef ENC_MULTIHOT_ERR_EN
        , .Err(err_l)
`endif
    );

    // Reference model: returns {index, valid}.
    // The highest set bit is floor(log2(d)).
    // The lowest set bit is log2 of the value isolated by d & -d.
    function automatic logic [3:0] model(input bit en_i, input logic [7:0] din_i, input bit msb);
        int d;
        int idx;
        if (!en_i) return 4'b0000;
        if (din_i == 8'h00) return 4'b0000;
        d = int'(din_i);
        if (msb) idx = $clog2(d + 1) - 1;
        else     idx = $clog2(d & -d);
        return {idx[2:0], 1'b1};
    endfunction

    function automatic logic [7:0] both(input bit en_i, input logic [7:0] din_i);
        return {model(en_i, din_i, 1'b1), model(en_i, din_i, 1'b0)};
    endfunction

    function automatic logic [7:0] observed();
        return {e0_m, v_m, e0_l, v_l};
    endfunction

    // Drives the inputs, waits for the next edge, and then settles.
    task automatic apply(input bit en_i, input logic [7:0] din_i);
        en  = en_i;
        din = din_i;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        #1 rst = 1'b1;
        #1;
        got = observed(); checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL reset_initial: got %h expected 00", got);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        apply(1'b1, 8'h80);
        got = observed(); checks++;
        if (got !== both(1'b1, 8'h80)) begin
            errors++; $display("FAIL reset_first_sample: got %h expected %h", got, both(1'b1, 8'h80));
        end
        // Assert rst mid-cycle: the outputs must clear before any edge.
        #2 rst = 1'b1;
        #1;
        got = observed(); checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL reset_async: got %h expected 00", got);
        end
        @(posedge clk); #1;
        got = observed(); checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL reset_held: got %h expected 00", got);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        got = observed(); checks++;
        if (got !== both(1'b1, 8'h80)) begin
            errors++; $display("FAIL reset_release: got %h expected %h", got, both(1'b1, 8'h80));
        end
        // The sample in flight at reset must not be reissued afterwards.
        #2 rst = 1'b1;
        en = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        got = observed(); checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL reset_discard: got %h expected 00", got);
        end
    endtask

    task automatic test_one_hot_sweep();
        logic [7:0] pats [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        logic [3:0] want [9] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB, 4'hD, 4'hF};
        logic [7:0] got;
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, pats[i]);
            got = observed(); checks++;
            if (got !== {want[i], want[i]} || got !== both(1'b1, pats[i])) begin
                errors++;
                $display("FAIL one_hot_%h: got %h expected %h", pats[i], got, {want[i], want[i]});
            end
        end
    endtask

    task automatic test_enable_gating();
        logic [7:0] got;
        apply(1'b0, 8'h20);
        got = observed(); checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL en_low: got %h expected 00", got);
        end
        apply(1'b0, 8'bx1z0_xx01);
        got = observed(); checks++;
        if (got !== 8'h00) begin
            errors++; $display("FAIL en_low_xz: got %h expected 00", got);
        end
        apply(1'b1, 8'h20);
        got = observed(); checks++;
        if (got !== 8'hBB) begin
            errors++; $display("FAIL en_rise: got %h expected bb", got);
        end
    endtask

    task automatic test_priority();
        logic [7:0] got;
        apply(1'b1, 8'h41);
        got = observed(); checks++;
        if (got !== {4'hD, 4'h1}) begin
            errors++; $display("FAIL prio_41: got %h expected d1", got);
        end
        apply(1'b1, 8'hFF);
        got = observed(); checks++;
        if (got !== {4'hF, 4'h1}) begin
            errors++; $display("FAIL prio_ff: got %h expected f1", got);
        end
    endtask

    task automatic test_latency();
        logic [7:0] got;
        apply(1'b1, 8'h08);
        #2 din = 8'h40;
        #1;
        got = observed(); checks++;
        if (got !== both(1'b1, 8'h08)) begin
            errors++; $display("FAIL latency_din_hold: got %h expected %h", got, both(1'b1, 8'h08));
        end
        en = 1'b0;
        #1;
        got = observed(); checks++;
        if (got !== both(1'b1, 8'h08)) begin
            errors++; $display("FAIL latency_en_hold: got %h expected %h", got, both(1'b1, 8'h08));
        end
        en = 1'b1;
        @(posedge clk); #1;
        got = observed(); checks++;
        if (got !== both(1'b1, 8'h40)) begin
            errors++; $display("FAIL latency_update: got %h expected %h", got, both(1'b1, 8'h40));
        end
    endtask

    task automatic test_random();
        logic [7:0] got;
        logic [7:0] d;
        bit         e;
        for (int i = 0; i < 200; i++) begin
            e = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'h01 << $urandom_range(0, 7);
                default: d = 8'($urandom);
            endcase
            apply(e, d);
            got = observed(); checks++;
            if (got !== both(e, d)) begin
                errors++; $display("FAIL random_%0d en=%0b din=%h: got %h expected %h", i, e, d, got, both(e, d));
            end
        end
    endtask

`ifdef ENC_MULTIHOT_ERR_EN
    task automatic test_multihot_err();
        logic [7:0] pats [5] = '{8'h18, 8'h10, 8'h00, 8'hFF, 8'h81};
        bit         ens  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        bit         want;
        for (int i = 0; i < 5; i++) begin
            apply(ens[i], pats[i]);
            want = ens[i] && ($countones(pats[i]) > 1);
            checks++;
            if ({err_m, err_l} !== {want, want}) begin
                errors++;
                $display("FAIL err_%h_en%0b: got %b%b expected %b%b", pats[i], ens[i], err_m, err_l, want, want);
            end
            checks++;
            if (observed() !== both(ens[i], pats[i])) begin
                errors++;
                $display("FAIL err_index_%h: got %h expected %h", pats[i], observed(), both(ens[i], pats[i]));
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_one_hot_sweep();
        test_enable_gating();
        test_priority();
        test_latency();
        test_random();
`ifdef ENC_MULTIHOT_ERR_EN
        test_multihot_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/encoder_8to3_12.md
Name: encoder_8to3_12

Overview:
- Registered 8-to-3 priority encoder with an enable input.
- Converts an 8-bit request/one-hot vector Din into the 3-bit index E0 of the winning set bit, plus a valid flag.
- Used as a leaf block wherever a one-hot select or request vector must be compressed to a binary index; one clock, one pipeline stage.

Parameters:
- MSB_PRIORITY, 1, selects which bit wins when several are set: 1 = highest-numbered set bit wins; 0 = lowest-numbered set bit wins.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- En   input  1  encode enable, sampled on the rising clk edge.
- Din  input  8  request vector; bit i set means index i is requested.
- E0   output 3  registered binary index of the winning Din bit.
- V    output 1  registered valid: high when E0 holds a real encoded index.

Behaviour:
- Reset: rst high asynchronously forces E0=3'b000 and V=0 immediately, independent of clk. Both outputs stay at those values while rst is high. The first update after deassertion happens on the next rising clk edge.
- Latency: exactly 1 clock. Din/En sampled at edge N appear on E0/V after edge N. No combinational path from Din or En to the outputs.
- En=1, Din nonzero: E0 = index of the winning set bit per MSB_PRIORITY; V=1.
- En=1, Din=8'h00: E0=3'b000, V=0. E0=0 with V=0 must be distinguishable from Din=8'h01, which gives E0=0 with V=1.
- En=0: E0=3'b000, V=0 on the next edge, regardless of Din. The outputs are cleared, not held.
- One-hot mapping (either priority): 01→0, 02→1, 04→2, 08→3, 10→4, 20→5, 40→6, 80→7.
- Multi-hot with MSB_PRIORITY=1: highest set index wins (e.g. 8'h41→6, 8'hFF→7). With MSB_PRIORITY=0: lowest set index wins (8'h41→0, 8'hFF→0).
- X/Z on Din while En=0 must not propagate to the outputs.
- rst asserted mid-stream: outputs clear immediately. Any sample in flight is discarded and is not reissued after reset.

Optional Feature:
- Macro: ENC_MULTIHOT_ERR_EN.
- Defined: adds output port Err (1 bit, registered, same 1-cycle latency).
  - Err=1 when En=1 and Din has more than one bit set; else 0.
  - Err resets asynchronously to 0 and is forced to 0 when En=0.
  - E0/V behave exactly as in the base design; the priority rule still applies.
- Not defined: no Err port and no popcount logic. The port list is exactly clk, rst, En, Din, E0, V.

Test Plan:
- Reset: assert rst mid-cycle with Din=8'h80, En=1 → E0=0 and V=0 immediately, before any clk edge. After release, the next edge gives E0=7, V=1.
- One-hot sweep: En=1, Din = 00,01,02,04,08,10,20,40,80, one per cycle → one cycle later (E0,V) = (0,0),(0,1),(1,1),(2,1),(3,1),(4,1),(5,1),(6,1),(7,1).
- Enable gating: En=0, Din=8'h20 → E0=0, V=0. Raise En=1 → next edge gives E0=5, V=1.
- Priority: MSB_PRIORITY=1 with Din=8'h41 → E0=6 and Din=8'hFF → E0=7. MSB_PRIORITY=0 with the same inputs → E0=0 for both.
- Latency: change Din between edges → E0 changes only at the following rising edge, never combinationally.
- ENC_MULTIHOT_ERR_EN defined: Din=8'h18, En=1 → Err=1, E0=4 (MSB_PRIORITY=1). Din=8'h10 → Err=0. En=0 → Err=0.
